inv_mix_columns_seq: RTL and testbench
======================================

INV_MIX_COLUMNS_SEQ -- requirements
Module: inv_mix_columns_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port list:
  clk       in   1    rising-edge clock
  rst_n     in   1    asynchronous active-low reset
  in_valid  in   1    in_state is valid
  in_ready  out  1    block can accept a state
  in_state  in   128  AES state; column c = bits [127-32c -: 32], row 0 in the MSB byte
  out_valid out  1    out_state is valid
  out_ready in   1    consumer accepts out_state
  out_state out  128  InvMixColumns(in_state), same byte layout
REQ-003 The block SHALL have no parameters; all widths are fixed.

Function
REQ-004 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE.
REQ-006 An accept SHALL occur on any rising edge where in_valid=1 and in_ready=1.
  - On accept, the block SHALL latch in_state into the working register, clear the column counter to 0 and go to BUSY.
REQ-007 In BUSY, each edge SHALL replace exactly one column (index = column counter, 0..3) with its InvMixColumns result and then increment the counter.
  - After column 3, the block SHALL go to DONE.
REQ-008 The column result SHALL be the GF(2^8) product with the circulant matrix rows [0E 0B 0D 09], [09 0E 0B 0D], [0D 09 0E 0B], [0B 0D 09 0E].
  - Reduction polynomial x^8+x^4+x^3+x+1 (0x11B).
  - Products SHALL be built from xtime chains (x2, x4, x8) plus XOR; no 256-entry tables.
REQ-009 out_valid SHALL be 1 only in DONE.
  - It SHALL rise on the 4th edge after the accept edge.
  - out_state SHALL equal the working register.
REQ-010 While out_valid=1 and out_ready=0, out_state and out_valid SHALL hold stable.
REQ-011 On an edge where out_valid=1 and out_ready=1, the block SHALL go to IDLE.
  - in_ready SHALL rise in the following cycle; there is no same-cycle re-accept.
  - Minimum period is 6 cycles per block.
REQ-012 in_state and in_valid SHALL be ignored outside IDLE.
  - out_ready SHALL be ignored outside DONE.
REQ-013 out_state SHALL be 0 in IDLE.
  - out_state SHALL show partial results in BUSY, but only the value under out_valid=1 is meaningful.
REQ-014 The column counter SHALL be 2 bits and SHALL wrap from 3 to 0 only via the BUSY-to-DONE transition.

Reset
REQ-015 rst_n=0 SHALL asynchronously force:
  - state to IDLE, counter to 0, working register to 0;
  - out_valid=0 and out_state=0.
REQ-016 in_ready SHALL be 1 during and after reset.
REQ-017 A reset asserted in BUSY or DONE SHALL abort the block with no output produced.
  - The first accept after release SHALL behave exactly as after power-up.

Structure
REQ-018 Shared package aes_pkg SHALL hold:
  - AES_STATE_W=128 and AES_POLY_LO=8'h1B;
  - the FSM state enum {IDLE, BUSY, DONE};
  - an xtime function.
REQ-019 A single combinational sub-module inv_mix_column SHALL map one 32-bit column to its 32-bit result.
  - The top level SHALL instantiate it once and time-share it across the 4 columns.
REQ-020 All flops SHALL be in the top level; inv_mix_column SHALL contain no state.

Verification
REQ-021 Per-column check: drive one block carrying each column vector; compare the corresponding out_state column.
  - 8E4DA1BC -> DB135345
  - 9FDC589D -> F20A225C
  - D5D5D7D6 -> D4D4D4D5
  - 01010101 -> 01010101
  - C6C6C6C6 -> C6C6C6C6
REQ-022 Full block: in_state = 8E4DA1BC_9FDC589D_01010101_C6C6C6C6 accepted at edge k.
  - Required: out_valid=1 after edge k+4.
  - Required: out_state = DB135345_F20A225C_01010101_C6C6C6C6.
REQ-023 Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - out_state SHALL stay constant and in_ready SHALL stay 0.
  - Raising out_ready SHALL complete the transfer; in_ready=1 in the next cycle.
REQ-024 Input ignore: toggle in_valid and in_state randomly during BUSY/DONE.
  - The result SHALL still equal the REQ-022 value.
REQ-025 Reset mid-operation: assert rst_n=0 asynchronously in BUSY (counter=2).
  - out_valid=0, out_state=0 and in_ready=1 SHALL hold immediately.
  - A new block after release SHALL give the correct result.
REQ-026 Round-trip: 1000 random states through a reference MixColumns model then this block SHALL return the original states.
  - Run with random in_valid and out_ready gaps.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: state width, reduction constant, FSM encoding
// and the GF(2^8) xtime primitive used by the column datapath.
package aes_pkg;

  localparam int         AES_STATE_W = 128;
  // Low byte of the reduction polynomial x^8+x^4+x^3+x+1 (0x11B).
  localparam logic [7:0] AES_POLY_LO = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // Multiply by x in GF(2^8): shift left, fold the carried-out bit back in.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_LO : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns for one 32-bit column (row 0 in the MSB byte).
// Each byte's x9/xB/xD/xE multiples come from an xtime chain plus XOR.
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] res
);

  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  for (genvar i = 0; i < 4; i++) begin : g_byte
    logic [7:0] a;
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;

    assign a  = col[31-8*i -: 8];
    assign x2 = xtime(a);
    assign x4 = xtime(x2);
    assign x8 = xtime(x4);

    assign m9[i] = x8 ^ a;
    assign mb[i] = x8 ^ x2 ^ a;
    assign md[i] = x8 ^ x4 ^ a;
    assign me[i] = x8 ^ x4 ^ x2;
  end

  // Circulant rows [0E 0B 0D 09] rotated one position per output byte.
  assign res[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
  assign res[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
  assign res[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
  assign res[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns: accepts a 128-bit state, runs one shared column
// unit over columns 0..3 on four consecutive edges, then holds the result
// under a valid/ready handshake until the consumer takes it.
module inv_mix_columns_seq
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state
);

  fsm_state_t             state;
  logic [1:0]             col_cnt;
  logic [AES_STATE_W-1:0] work;
  logic [31:0]            col_in;
  logic [31:0]            col_res;

  // Route the column addressed by the counter into the shared unit.
  always_comb begin
    // NOTE: a default before the case keeps this purely combinational; a missed branch would otherwise infer a latch.
    col_in = 32'h0;
    case (col_cnt)
      2'd0: col_in = work[127:96];
      2'd1: col_in = work[95:64];
      2'd2: col_in = work[63:32];
      2'd3: col_in = work[31:0];
      default: col_in = 32'h0;
    endcase
  end

  inv_mix_column u_inv_mix_column (
    .col (col_in),
    .res (col_res)
  );

  // Control FSM, column counter and in-place column write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      col_cnt <= 2'd0;
      // NOTE: the working register is reset too, so an aborted block leaves nothing behind and out_state reads 0.
      work    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop here samples pre-edge values.
      case (state)
        IDLE: begin
          if (in_valid) begin
            work    <= in_state;
            col_cnt <= 2'd0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          case (col_cnt)
            2'd0: work[127:96] <= col_res;
            2'd1: work[95:64]  <= col_res;
            2'd2: work[63:32]  <= col_res;
            2'd3: work[31:0]   <= col_res;
            default: work      <= work;
          endcase
          // Wraps 3 -> 0 exactly on the edge that moves to DONE.
          col_cnt <= col_cnt + 2'd1;
          if (col_cnt == 2'd3) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  // Partial results are visible while BUSY; only the DONE value is meaningful.
  assign out_state = (state == IDLE) ? '0 : work;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: directed column vectors,
// latency, backpressure, input-ignore, mid-block reset, and a random
// round-trip through a forward MixColumns model with a scoreboard queue.
module tb_inv_mix_columns_seq;

  localparam int N_RT   = 1000;
  localparam int BUDGET = 40000;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q [$];

  localparam logic [127:0] FULL_IN  = 128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6;
  localparam logic [127:0] FULL_OUT = 128'hDB135345_F20A225C_01010101_C6C6C6C6;

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Forward MixColumns on one column.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
            a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
            a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
            gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
  endfunction

  function automatic logic [127:0] mix_state(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one block (called at a negedge), check latency, optional
  // backpressure hold and input jitter, then complete the transfer.
  task automatic do_block(input string tag, input logic [127:0] st, input logic [127:0] exp,
                          input int hold, input bit jitter, output logic [127:0] got);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " in_ready before accept"}, in_ready, 1);
    in_valid = 1'b1;
    in_state = st;
    @(negedge clk);
    in_valid = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      if (jitter) begin
        in_valid = 1'($urandom_range(0, 1));
        in_state = rand128();
      end
      @(negedge clk);
      check($sformatf("%s out_valid edge+%0d", tag, e), out_valid, (e == 4) ? 1 : 0);
      check($sformatf("%s in_ready edge+%0d", tag, e), in_ready, 0);
    end
    got = out_state;
    check({tag, " result"}, got, exp);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      if (jitter) begin
        in_valid = 1'($urandom_range(0, 1));
        in_state = rand128();
      end
      @(negedge clk);
      check($sformatf("%s hold%0d out_state", tag, h), out_state, got);
      check($sformatf("%s hold%0d out_valid", tag, h), out_valid, 1);
      check($sformatf("%s hold%0d in_ready", tag, h), in_ready, 0);
    end
    out_ready = 1'b1;
    if (jitter) begin
      in_valid = 1'($urandom_range(0, 1));
      in_state = rand128();
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, " in_ready after transfer"}, in_ready, 1);
    check({tag, " out_valid after transfer"}, out_valid, 0);
    check({tag, " out_state idle"}, out_state, 128'h0);
  endtask

  logic [31:0]  col_vec [5];
  logic [31:0]  col_exp [5];
  logic [127:0] got;

  initial begin
    col_vec = '{32'h8E4DA1BC, 32'h9FDC589D, 32'hD5D5D7D6, 32'h01010101, 32'hC6C6C6C6};
    col_exp = '{32'hDB135345, 32'hF20A225C, 32'hD4D4D4D5, 32'h01010101, 32'hC6C6C6C6};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = '0;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_state", out_state, 128'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset in_ready", in_ready, 1);
    check("post-reset out_valid", out_valid, 0);

    // Each vector in one column, the other columns zero (which map to zero).
    for (int i = 0; i < 5; i++) begin
      int c;
      logic [127:0] st;
      logic [127:0] ex;
      c  = i % 4;
      st = {96'h0, col_vec[i]} << (96 - 32 * c);
      ex = {96'h0, col_exp[i]} << (96 - 32 * c);
      do_block($sformatf("col%0d", i), st, ex, 0, 1'b0, got);
      check($sformatf("col%0d column", i), got[127-32*c -: 32], col_exp[i]);
    end

    do_block("full", FULL_IN, FULL_OUT, 0, 1'b0, got);
    do_block("backpressure", FULL_IN, FULL_OUT, 10, 1'b0, got);
    do_block("ignore", FULL_IN, FULL_OUT, 3, 1'b1, got);

    // Reset while BUSY with the counter at 2.
    in_valid = 1'b1;
    in_state = FULL_IN;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre-abort in_ready", in_ready, 0);
    check("pre-abort out_valid", out_valid, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort out_state", out_state, 128'h0);
    check("abort in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_block("after-abort", FULL_IN, FULL_OUT, 0, 1'b0, got);

    // Random round-trip with gaps on both sides.
    fork
      begin : drv
        int sent;
        int cyc;
        bit pending;
        logic [127:0] orig;
        sent    = 0;
        cyc     = 0;
        pending = 1'b0;
        orig    = '0;
        while (sent < N_RT && cyc < BUDGET) begin
          @(negedge clk);
          cyc++;
          if (pending) begin
            in_valid = 1'b0;
            pending  = 1'b0;
          end
          if (!in_valid && $urandom_range(0, 3) != 0) begin
            orig     = rand128();
            in_state = mix_state(orig);
            in_valid = 1'b1;
          end
          if (in_valid && in_ready) begin
            exp_q.push_back(orig);
            sent++;
            pending = 1'b1;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("rt sent count", sent, N_RT);
      end
      begin : mon
        int got_n;
        int cyc;
        got_n = 0;
        cyc   = 0;
        while (got_n < N_RT && cyc < BUDGET) begin
          @(negedge clk);
          cyc++;
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check("rt scoreboard empty", 1, 0);
            end else begin
              check($sformatf("roundtrip %0d", got_n), out_state, exp_q.pop_front());
            end
            got_n++;
          end
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("rt received count", got_n, N_RT);
      end
    join
    check("rt scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
